pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Pipeline sequencing controller for the five-stage pipelined CPU. It sits alongside the EX-stage forwarding unit: forwarding resolves ALU-to-ALU dependencies, and this block handles everything forwarding cannot. It produces per-latch enables and flushes for IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC enable. It covers load-use stalls, data-memory wait stalls, taken-branch and jump flushes, instruction-fetch misses and halt, and keeps saturating stall/flush performance counters.

## Interface
- CNTW, 16, width of each performance counter
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-high reset
- ihit  input  1  instruction memory returned fetch this cycle
- dhit  input  1  data memory completed MEM-stage access this cycle
- dREN_out_3, dWEN_out_3  input  1 each  MEM-stage (EX/MEM latch) load/store request
- MemRead_out_2  input  1  EX-stage (ID/EX latch) instruction is a load
- wsel_out_2  input  regbits_t(5)  EX-stage destination register
- rs_out_1, rt_out_1  input  regbits_t(5)  ID-stage source registers
- rt_used_1  input  1  ID-stage instruction reads rt as a source
- jump_out_2  input  1  EX-stage J/JAL/JR resolved
- branch_taken_out_3  input  1  MEM-stage branch resolved taken
- halt_out_4  input  1  WB-stage (MEM/WB latch) holds HALT
- pc_en  output  1  PC register load enable
- en_ifid, en_idex, en_exmem, en_memwb  output  1 each  latch enables
- flush_ifid, flush_idex, flush_exmem  output  1 each  synchronous bubble insert (takes priority over enable at the latch)
- halt  output  1  sticky CPU halt
- stall_cnt, flush_cnt  output  CNTW each  saturating performance counters

## Operation
- FSM states: RUN, DWAIT, HALTED.
- Reset: state=RUN, halt=0, counters=0. While RST is high, all en_*/pc_en=0 and all flush_*=0.
- mem_req = dREN_out_3 | dWEN_out_3.
- load_use = MemRead_out_2 & (wsel_out_2!=0) & ((wsel_out_2==rs_out_1) | (rt_used_1 & wsel_out_2==rt_out_1)).
- Per-cycle decision in RUN/DWAIT, first matching rule wins:
  1. halt_out_4: all enables 0, no flush; next state HALTED.
  2. mem_req & !dhit: all enables 0, no flush (full freeze); next state DWAIT.
  3. branch_taken_out_3: all enables 1, pc_en=1, flush_ifid=flush_idex=flush_exmem=1. PC loads the target regardless of ihit.
  4. jump_out_2: all enables 1, pc_en=1, flush_ifid=flush_idex=1.
  5. load_use: pc_en=0, en_ifid=0, flush_idex=1, en_exmem=en_memwb=1.
  6. !ihit: pc_en=0, flush_ifid=1, en_idex=en_exmem=en_memwb=1.
  7. Otherwise: all enables 1, no flush.
- A rule-2 cycle never also flushes. A branch or jump seen during a freeze is acted on in the first unfrozen cycle.
- DWAIT→RUN on the cycle dhit=1; that cycle evaluates rules 3–7 normally.
- HALTED: all enables 0, flushes 0, halt=1. Leaves only by reset.
- stall_cnt increments in any non-HALTED, non-reset cycle with pc_en=0. flush_cnt increments in any cycle with any flush_* high. Both saturate at 2^CNTW−1 and never wrap.

## Timing
- All enable/flush/pc_en outputs are combinational from the current inputs and state; there is zero-cycle latency to the latches.
- halt, the state and the counters update on the CLK rising edge. halt goes high the edge after halt_out_4 is first seen.
- Load-use inserts exactly one bubble: the bubble clears MemRead_out_2, so rule 5 is not re-triggered.
- RST asserted mid-stall or mid-HALTED returns to RUN immediately, asynchronously, with counters cleared.

## Test plan
- Load-use: MemRead_out_2=1, wsel_out_2=5, rs_out_1=5, ihit=1 → one cycle with pc_en=0, en_ifid=0, flush_idex=1; next cycle all enables 1; stall_cnt=1.
- Register $0 load: wsel_out_2=0, rs_out_1=0 → no stall; all enables 1.
- Dmem wait: dREN_out_3=1, dhit=0 for 3 cycles, then dhit=1 → 3 cycles with all enables 0 in DWAIT, then advance; stall_cnt=3.
- Priority: branch_taken_out_3=1 and load_use both true → all three flushes set, pc_en=1, no load-use stall; flush_cnt=1.
- Halt: halt_out_4=1 with dREN_out_3=1, dhit=0 → halt=1 after one edge, enables stay 0 across 10 further cycles; RST pulse → halt=0, state RUN.
- Saturation: CNTW=4, hold ihit=0 for 20 cycles → stall_cnt=15 and holds at 15.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//
// Sequencing controller for the five-stage pipelined CPU. It works next to
// the EX-stage forwarding unit and handles every hazard that forwarding
// cannot: load-use stalls, data-memory wait freezes, taken-branch and jump
// flushes, instruction-fetch misses and HALT. It drives the PC enable and the
// per-latch enables and flushes, and keeps two saturating performance
// counters (stall cycles, flush cycles).
//
// Handshake semantics (single place): the memories signal completion with a
// one-cycle hit pulse (ihit/dhit). A MEM-stage request (dREN_out_3 |
// dWEN_out_3) is outstanding until the cycle dhit is high; the whole pipeline
// is frozen while it is outstanding. There is no backpressure toward the
// memories beyond holding the request steady in the frozen EX/MEM latch.
//
// Ports
//   CLK, RST                  clock (rising edge), async active-high reset
//   ihit, dhit                fetch / data access completed this cycle
//   dREN_out_3, dWEN_out_3    MEM-stage load / store request
//   MemRead_out_2             EX-stage instruction is a load
//   wsel_out_2                EX-stage destination register
//   rs_out_1, rt_out_1        ID-stage source registers
//   rt_used_1                 ID-stage instruction reads rt
//   jump_out_2                EX-stage jump resolved
//   branch_taken_out_3        MEM-stage branch resolved taken
//   halt_out_4                WB-stage holds HALT
//   pc_en, en_*               PC / latch load enables (combinational)
//   flush_*                   latch bubble inserts (combinational)
//   halt                      sticky halt, set the edge after HALT is seen
//   stall_cnt, flush_cnt      saturating performance counters
//   dbg_state                 current FSM state for observation
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            dREN_out_3,
    input  logic            dWEN_out_3,
    input  logic            MemRead_out_2,
    input  logic [4:0]      wsel_out_2,
    input  logic [4:0]      rs_out_1,
    input  logic [4:0]      rt_out_1,
    input  logic            rt_used_1,
    input  logic            jump_out_2,
    input  logic            branch_taken_out_3,
    input  logic            halt_out_4,
    output logic            pc_en,
    output logic            en_ifid,
    output logic            en_idex,
    output logic            en_exmem,
    output logic            en_memwb,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            flush_exmem,
    output logic            halt,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DWAIT  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    state_t          r_state;
    state_t          w_next_state;
    logic [CNTW-1:0] r_stall_cnt;
    logic [CNTW-1:0] r_flush_cnt;

    logic w_mem_req;
    logic w_rs_hit;
    logic w_rt_hit;
    logic w_load_use;
    logic w_any_flush;
    logic w_stall_inc;
    logic w_flush_inc;

    // Hazard terms. A load into $0 never creates a dependency because $0
    // always reads as zero.
    assign w_mem_req  = dREN_out_3 | dWEN_out_3;
    assign w_rs_hit   = (wsel_out_2 == rs_out_1);
    assign w_rt_hit   = rt_used_1 & (wsel_out_2 == rt_out_1);
    assign w_load_use = MemRead_out_2 & (wsel_out_2 != 5'd0) & (w_rs_hit | w_rt_hit);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and per-cycle decision. RUN and DWAIT apply the same
    // priority list; DWAIT only records that a data access is being waited
    // on. Inputs are held by the frozen latches, so a branch or jump that
    // arrives during a freeze is naturally acted on in the first unfrozen
    // cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        pc_en        = 1'b0;
        en_ifid      = 1'b0;
        en_idex      = 1'b0;
        en_exmem     = 1'b0;
        en_memwb     = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        flush_exmem  = 1'b0;

        if (!RST) begin
            case (r_state)
                S_RUN, S_DWAIT: begin
                    if (halt_out_4) begin
                        w_next_state = S_HALTED;
                    end else if (w_mem_req && !dhit) begin
                        // Full freeze: nothing moves and nothing is flushed.
                        w_next_state = S_DWAIT;
                    end else begin
                        w_next_state = S_RUN;
                        if (branch_taken_out_3) begin
                            // PC takes the branch target even on a fetch miss;
                            // the wrong-path IF/ID content is flushed anyway.
                            pc_en       = 1'b1;
                            en_ifid     = 1'b1;
                            en_idex     = 1'b1;
                            en_exmem    = 1'b1;
                            en_memwb    = 1'b1;
                            flush_ifid  = 1'b1;
                            flush_idex  = 1'b1;
                            flush_exmem = 1'b1;
                        end else if (jump_out_2) begin
                            pc_en      = 1'b1;
                            en_ifid    = 1'b1;
                            en_idex    = 1'b1;
                            en_exmem   = 1'b1;
                            en_memwb   = 1'b1;
                            flush_ifid = 1'b1;
                            flush_idex = 1'b1;
                        end else if (w_load_use) begin
                            // Hold PC and IF/ID, push a bubble into ID/EX.
                            // The bubble clears MemRead_out_2 so this fires
                            // exactly once per dependency.
                            en_idex    = 1'b1;
                            flush_idex = 1'b1;
                            en_exmem   = 1'b1;
                            en_memwb   = 1'b1;
                        end else if (!ihit) begin
                            // No fetched instruction: hold PC, bubble IF/ID,
                            // let the rest of the pipe drain forward.
                            en_ifid    = 1'b1;
                            flush_ifid = 1'b1;
                            en_idex    = 1'b1;
                            en_exmem   = 1'b1;
                            en_memwb   = 1'b1;
                        end else begin
                            pc_en    = 1'b1;
                            en_ifid  = 1'b1;
                            en_idex  = 1'b1;
                            en_exmem = 1'b1;
                            en_memwb = 1'b1;
                        end
                    end
                end
                S_HALTED: begin
                    w_next_state = S_HALTED;
                end
                default: begin
                    w_next_state = S_RUN;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Performance counters. A stall cycle is any live (non-halted) cycle in
    // which the PC does not advance; a flush cycle is any cycle with at least
    // one bubble inserted. Both stop at all-ones instead of wrapping.
    // -----------------------------------------------------------------------
    assign w_any_flush = flush_ifid | flush_idex | flush_exmem;
    assign w_stall_inc = (r_state != S_HALTED) && !pc_en && (r_stall_cnt != CNT_MAX);
    assign w_flush_inc = w_any_flush && (r_flush_cnt != CNT_MAX);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_inc) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign halt      = (r_state == S_HALTED);
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for pipeline_ctrl. Directed cases for the listed scenarios followed by
// randomized traffic with occasional asynchronous resets. Expected control
// outputs and counters come from a rule-table model kept in this file.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam int CNTW   = 4;
    localparam int CNTMAX = (1 << CNTW) - 1;

    logic            CLK;
    logic            RST;
    logic            ihit, dhit, dREN_out_3, dWEN_out_3, MemRead_out_2;
    logic [4:0]      wsel_out_2, rs_out_1, rt_out_1;
    logic            rt_used_1, jump_out_2, branch_taken_out_3, halt_out_4;
    logic            pc_en, en_ifid, en_idex, en_exmem, en_memwb;
    logic            flush_ifid, flush_idex, flush_exmem, halt;
    logic [CNTW-1:0] stall_cnt, flush_cnt;
    logic [1:0]      dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_halted;
    int m_stall;
    int m_flush;

    pipeline_ctrl #(.CNTW(CNTW)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dREN_out_3(dREN_out_3), .dWEN_out_3(dWEN_out_3),
        .MemRead_out_2(MemRead_out_2), .wsel_out_2(wsel_out_2),
        .rs_out_1(rs_out_1), .rt_out_1(rt_out_1), .rt_used_1(rt_used_1),
        .jump_out_2(jump_out_2), .branch_taken_out_3(branch_taken_out_3),
        .halt_out_4(halt_out_4), .pc_en(pc_en), .en_ifid(en_ifid),
        .en_idex(en_idex), .en_exmem(en_exmem), .en_memwb(en_memwb),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .flush_exmem(flush_exmem), .halt(halt), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] ctl_vec();
        return {pc_en, en_ifid, en_idex, en_exmem, en_memwb,
                flush_ifid, flush_idex, flush_exmem};
    endfunction

    // Rule table: bit order {pc, ifid, idex, exmem, memwb, fl_ifid, fl_idex, fl_exmem}.
    // The mask drops an enable whose latch is being flushed in the same cycle,
    // since the flush decides that latch's contents.
    task automatic model_ctl(output logic [7:0] e, output logic [7:0] m);
        bit lu;
        lu = MemRead_out_2 && (wsel_out_2 != 0) &&
             ((wsel_out_2 == rs_out_1) || (rt_used_1 && wsel_out_2 == rt_out_1));
        m = 8'hFF;
        if (m_halted || halt_out_4)                       e = 8'b0000_0000;
        else if ((dREN_out_3 || dWEN_out_3) && !dhit)     e = 8'b0000_0000;
        else if (branch_taken_out_3)                      e = 8'b1111_1111;
        else if (jump_out_2)                              e = 8'b1111_1110;
        else if (lu) begin                                e = 8'b0001_1010; m[5] = 1'b0; end
        else if (!ihit) begin                             e = 8'b0011_1100; m[6] = 1'b0; end
        else                                              e = 8'b1111_1000;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        ihit = 1; dhit = 0; dREN_out_3 = 0; dWEN_out_3 = 0; MemRead_out_2 = 0;
        wsel_out_2 = 0; rs_out_1 = 0; rt_out_1 = 0; rt_used_1 = 0;
        jump_out_2 = 0; branch_taken_out_3 = 0; halt_out_4 = 0;
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model at
    // the edge, then check registered outputs just after it.
    task automatic step();
        logic [7:0] e, m;
        @(negedge CLK);
        model_ctl(e, m);
        chk("ctl", {24'd0, ctl_vec() & m}, {24'd0, e & m});
        if (!m_halted && !e[7] && m_stall < CNTMAX) m_stall++;
        if ((|e[2:0]) && m_flush < CNTMAX) m_flush++;
        if (halt_out_4) m_halted = 1;
        @(posedge CLK);
        #1;
        chk("halt", {31'd0, halt}, {31'd0, m_halted});
        chk("stall_cnt", {28'd0, stall_cnt}, m_stall);
        chk("flush_cnt", {28'd0, flush_cnt}, m_flush);
    endtask

    // Asynchronous reset pulse starting mid-cycle.
    task automatic do_reset();
        #2 RST = 1;
        #1;
        chk("rst_ctl", {24'd0, ctl_vec()}, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_stall", {28'd0, stall_cnt}, 32'd0);
        chk("rst_flush", {28'd0, flush_cnt}, 32'd0);
        m_halted = 0; m_stall = 0; m_flush = 0;
        @(posedge CLK);
        #1;
        chk("rst_hold_ctl", {24'd0, ctl_vec()}, 32'd0);
        RST = 0;
    endtask

    task automatic randomize_inputs();
        ihit               = ($urandom_range(0, 3) != 0);
        dhit               = ($urandom_range(0, 1) == 1);
        dREN_out_3         = ($urandom_range(0, 3) == 0);
        dWEN_out_3         = ($urandom_range(0, 5) == 0);
        MemRead_out_2      = ($urandom_range(0, 2) == 0);
        wsel_out_2         = 5'($urandom_range(0, 3));
        rs_out_1           = 5'($urandom_range(0, 3));
        rt_out_1           = 5'($urandom_range(0, 3));
        rt_used_1          = ($urandom_range(0, 1) == 1);
        jump_out_2         = ($urandom_range(0, 7) == 0);
        branch_taken_out_3 = ($urandom_range(0, 7) == 0);
        halt_out_4         = ($urandom_range(0, 49) == 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST = 0;
        set_idle();
        m_halted = 0; m_stall = 0; m_flush = 0;
        #1;
        do_reset();

        // Load-use on rs: one bubble, then normal flow.
        MemRead_out_2 = 1; wsel_out_2 = 5; rs_out_1 = 5;
        step();
        chk("lu_stall_cnt", {28'd0, stall_cnt}, 32'd1);
        MemRead_out_2 = 0;
        step();
        chk("lu_after_ctl", {24'd0, ctl_vec()}, 32'hF8);

        // Load into $0: no dependency.
        do_reset();
        MemRead_out_2 = 1; wsel_out_2 = 0; rs_out_1 = 0;
        step();
        chk("r0_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        set_idle();

        // Data memory wait: three frozen cycles then completion.
        do_reset();
        dREN_out_3 = 1; dhit = 0;
        repeat (3) step();
        dhit = 1;
        step();
        chk("dwait_stall_cnt", {28'd0, stall_cnt}, 32'd3);
        set_idle();

        // Branch beats load-use.
        do_reset();
        branch_taken_out_3 = 1; MemRead_out_2 = 1; wsel_out_2 = 7; rs_out_1 = 7;
        step();
        chk("prio_flush_cnt", {28'd0, flush_cnt}, 32'd1);
        chk("prio_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        set_idle();

        // Jump during a freeze, acted on once dhit arrives.
        do_reset();
        jump_out_2 = 1; dWEN_out_3 = 1; dhit = 0;
        repeat (2) step();
        dhit = 1;
        step();
        chk("jfreeze_flush_cnt", {28'd0, flush_cnt}, 32'd1);
        set_idle();

        // Halt beats a pending data access, then stays halted.
        do_reset();
        halt_out_4 = 1; dREN_out_3 = 1; dhit = 0;
        step();
        chk("halt_set", {31'd0, halt}, 32'd1);
        set_idle();
        repeat (10) step();
        do_reset();
        chk("halt_cleared", {31'd0, halt}, 32'd0);
        step();

        // Saturation: fetch misses for 20 cycles.
        do_reset();
        ihit = 0;
        repeat (20) step();
        chk("sat_stall_cnt", {28'd0, stall_cnt}, CNTMAX);
        chk("sat_flush_cnt", {28'd0, flush_cnt}, CNTMAX);
        set_idle();

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            randomize_inputs();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
